// File: rtl/bsg_down_io_pack_fifo.sv
// Downstream IO input stage: packs PACK beats of IO_W bits into one word,
// buffers words in a wrap-bit pointer FIFO, presents them FWFT to the core
// and returns one credit token every TOKEN_RATIO dequeued words.
module bsg_down_io_pack_fifo #(
    parameter int IO_W        = 8,
    parameter int PACK        = 2,
    parameter int DEPTH_LOG2  = 6,
    parameter int TOKEN_RATIO = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_valid_in,
    input  logic [IO_W-1:0]       io_data_in,
    input  logic                  core_ready,
    output logic                  core_valid_out,
    output logic [PACK*IO_W-1:0]  core_data_out,
    output logic                  io_token_out,
    output logic [DEPTH_LOG2:0]   count_out,
    output logic                  overflow_out
);
    localparam int W     = PACK * IO_W;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int BW    = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int TW    = (TOKEN_RATIO > 1) ? $clog2(TOKEN_RATIO) : 1;

    logic [BW-1:0]         beat;
    logic [TW-1:0]         tcnt;
    logic [DEPTH_LOG2:0]   wptr, rptr;
    logic [W-1:0]          word;
    logic [W-1:0]          mem [DEPTH];
    logic                  last_beat, empty, full, wr, rd, drop;

    assign last_beat = (beat == BW'(PACK - 1));
    assign empty     = (wptr == rptr);
    assign full      = (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]) &&
                       (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]);
    // Full is judged on registered pointers, so a same-cycle dequeue never
    // frees room for the incoming word.
    assign wr        = io_valid_in && last_beat && !full;
    assign drop      = io_valid_in && last_beat && full;
    assign rd        = core_ready && !empty;

    assign core_valid_out = !empty;
    assign core_data_out  = mem[rptr[DEPTH_LOG2-1:0]];
    assign count_out      = wptr - rptr;

    // Staging holds beats 0..PACK-2; the final beat goes straight into the word.
    generate
        if (PACK > 1) begin : g_stage
            logic [PACK-2:0][IO_W-1:0] stage;

            // Capture non-final beats into their slot.
            always_ff @(posedge clk) begin
                for (int i = 0; i < PACK - 1; i++)
                    if (io_valid_in && beat == BW'(i)) stage[i] <= io_data_in;
            end

            assign word = {io_data_in, stage};
        end else begin : g_nostage
            assign word = io_data_in;
        end
    endgenerate

    // Beat counter; returns to 0 after the final beat even if the word is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              beat <= '0;
        else if (io_valid_in) beat <= last_beat ? '0 : beat + 1'b1;
    end

    // Word storage; not reset, contents only meaningful while valid.
    always_ff @(posedge clk) begin
        if (wr) mem[wptr[DEPTH_LOG2-1:0]] <= word;
    end

    // Wrap-bit pointers and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (wr)   wptr         <= wptr + 1'b1;
            if (rd)   rptr         <= rptr + 1'b1;
            if (drop) overflow_out <= 1'b1;
        end
    end

    // Credit return: one registered pulse per TOKEN_RATIO dequeues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt         <= '0;
            io_token_out <= 1'b0;
        end else begin
            io_token_out <= 1'b0;
            if (rd) begin
                if (tcnt == TW'(TOKEN_RATIO - 1)) begin
                    tcnt         <= '0;
                    io_token_out <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bsg_down_io_pack_fifo.sv
// Directed bench: three configurations (8/2/4x1, 8/2/4x3 tokens, 4-bit x4 pack).
module tb_bsg_down_io_pack_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // instance 0: IO_W=8 PACK=2 DEPTH_LOG2=2 TOKEN_RATIO=1
    logic        v0 = 0, r0 = 0;
    logic [7:0]  d0 = 0;
    logic        cv0, tok0, ov0;
    logic [15:0] cd0;
    logic [2:0]  cnt0;
    // instance 1: TOKEN_RATIO=3
    logic        v1 = 0, r1 = 0;
    logic [7:0]  d1 = 0;
    logic        cv1, tok1, ov1;
    logic [15:0] cd1;
    logic [2:0]  cnt1;
    // instance 2: IO_W=4 PACK=4
    logic        v2 = 0, r2 = 0;
    logic [3:0]  d2 = 0;
    logic        cv2, tok2, ov2;
    logic [15:0] cd2;
    logic [2:0]  cnt2;

    bsg_down_io_pack_fifo #(.IO_W(8), .PACK(2), .DEPTH_LOG2(2), .TOKEN_RATIO(1)) u0 (
        .clk(clk), .rst(rst), .io_valid_in(v0), .io_data_in(d0), .core_ready(r0),
        .core_valid_out(cv0), .core_data_out(cd0), .io_token_out(tok0),
        .count_out(cnt0), .overflow_out(ov0));
    bsg_down_io_pack_fifo #(.IO_W(8), .PACK(2), .DEPTH_LOG2(2), .TOKEN_RATIO(3)) u1 (
        .clk(clk), .rst(rst), .io_valid_in(v1), .io_data_in(d1), .core_ready(r1),
        .core_valid_out(cv1), .core_data_out(cd1), .io_token_out(tok1),
        .count_out(cnt1), .overflow_out(ov1));
    bsg_down_io_pack_fifo #(.IO_W(4), .PACK(4), .DEPTH_LOG2(2), .TOKEN_RATIO(1)) u2 (
        .clk(clk), .rst(rst), .io_valid_in(v2), .io_data_in(d2), .core_ready(r2),
        .core_valid_out(cv2), .core_data_out(cd2), .io_token_out(tok2),
        .count_out(cnt2), .overflow_out(ov2));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat0(input logic [7:0] d, input logic rdy);
        v0 = 1'b1; d0 = d; r0 = rdy;
        tick();
        v0 = 1'b0; r0 = 1'b0;
    endtask

    task automatic beat2(input logic [3:0] d, input logic rdy);
        v2 = 1'b1; d2 = d; r2 = rdy;
        tick();
        v2 = 1'b0; r2 = 1'b0;
    endtask

    initial begin
        int ntok, k, maxc, ndeq;
        logic pv;
        logic [15:0] w;

        #12 rst = 1'b0;
        #1;
        // reset state
        chk("rst_valid", cv0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_token", tok0, 0);
        chk("rst_ovf",   ov0, 0);

        // single word, then dequeue with token pulse
        beat0(8'h11, 0);
        chk("half_valid", cv0, 0);
        beat0(8'h22, 0);
        chk("w1_valid", cv0, 1);
        chk("w1_data",  cd0, 16'h2211);
        chk("w1_count", cnt0, 1);
        r0 = 1'b1; tick(); r0 = 1'b0;
        chk("w1_token", tok0, 1);
        chk("w1_count_after", cnt0, 0);
        chk("w1_valid_after", cv0, 0);
        tick();
        chk("w1_token_end", tok0, 0);

        // fill to full, then overflow
        for (int i = 0; i < 4; i++) begin
            beat0(8'h30 + 8'(i), 0);
            beat0(8'h40 + 8'(i), 0);
        end
        chk("full_count", cnt0, 4);
        chk("full_ovf",   ov0, 0);
        beat0(8'hAA, 0);
        beat0(8'hBB, 0);
        chk("ovf_set",   ov0, 1);
        chk("ovf_count", cnt0, 4);
        chk("ovf_head",  cd0, 16'h4030);
        // final beat while full with simultaneous dequeue: still dropped
        beat0(8'hCC, 0);
        beat0(8'hDD, 1);
        chk("full_deq_count", cnt0, 3);
        for (int i = 1; i < 4; i++) begin
            chk("drain_data", cd0, {8'h40 + 8'(i), 8'h30 + 8'(i)});
            r0 = 1'b1; tick(); r0 = 1'b0;
        end
        chk("drain_empty", cv0, 0);
        chk("drain_ovf_sticky", ov0, 1);

        // continuous streaming with core_ready high
        ntok = 0; k = 0; maxc = 0;
        r0 = 1'b1;
        for (int i = 0; i < 42; i++) begin
            if (i < 40) begin
                v0 = 1'b1;
                d0 = (i % 2 == 0) ? 8'(i / 2) : (8'(i / 2) ^ 8'h5A);
            end else begin
                v0 = 1'b0;
            end
            tick();
            if (tok0) ntok++;
            if (32'(cnt0) > maxc) maxc = 32'(cnt0);
            if (cv0) begin
                w = {8'(k) ^ 8'h5A, 8'(k)};
                chk("stream_data", cd0, w);
                k++;
            end
        end
        v0 = 1'b0; r0 = 1'b0;
        tick();
        if (tok0) ntok++;
        chk("stream_words",  k, 20);
        chk("stream_tokens", ntok, 20);
        chk("stream_maxcnt", maxc, 1);

        // reset mid-word discards the partial beat and clears overflow
        beat0(8'h77, 0);
        rst = 1'b1; #2 rst = 1'b0;
        #1;
        chk("mid_rst_count", cnt0, 0);
        chk("mid_rst_ovf",   ov0, 0);
        beat0(8'h01, 0);
        beat0(8'h02, 0);
        chk("mid_rst_data",  cd0, 16'h0201);
        chk("mid_rst_valid", cv0, 1);

        // TOKEN_RATIO=3: 7 dequeues -> tokens after 3rd and 6th
        ntok = 0; ndeq = 0; pv = 1'b0;
        r1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i < 14) begin v1 = 1'b1; d1 = 8'(i); end
            else v1 = 1'b0;
            tick();
            if (pv) ndeq++;
            if (tok1) begin
                ntok++;
                chk("tok3_pos", ndeq == 3 || ndeq == 6, 1);
            end
            pv = cv1;
        end
        v1 = 1'b0; r1 = 1'b0;
        chk("tok3_deqs",  ndeq, 7);
        chk("tok3_count", ntok, 2);

        // PACK=4 IO_W=4
        beat2(4'h1, 0); beat2(4'h2, 0); beat2(4'h3, 0);
        chk("p4_partial", cv2, 0);
        beat2(4'h4, 0);
        chk("p4_data",  cd2, 16'h4321);
        chk("p4_count", cnt2, 1);
        beat2(4'h5, 0); beat2(4'h6, 0); beat2(4'h7, 0); beat2(4'h8, 0);
        chk("p4_count2", cnt2, 2);
        beat2(4'h9, 0); beat2(4'hA, 0); beat2(4'hB, 0); beat2(4'hC, 1);
        chk("p4_simul_count", cnt2, 2);
        chk("p4_simul_head",  cd2, 16'h8765);
        r2 = 1'b1; tick(); r2 = 1'b0;
        chk("p4_last", cd2, 16'hCBA9);
        chk("p4_last_count", cnt2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bsg_down_io_pack_fifo.md
# bsg_down_io_pack_fifo

Downstream input stage of the off-chip link, parametrised successor to the fixed 8-bit/2-beat/64-entry downstream data-in path. Collects `PACK` consecutive `IO_W`-bit beats from the IO side into one `PACK*IO_W`-bit word and enqueues it into a `2**DEPTH_LOG2`-entry buffer with wrap-bit pointers. Presents words to the core with a first-word-fall-through valid/ready interface and returns credit tokens to the transmitter at a configurable ratio. Adds occupancy reporting and sticky overflow detection.

## Interface
- `IO_W`, 8: IO beat width in bits (>=1).
- `PACK`, 2: beats per word (>=1); word width `W = PACK*IO_W`.
- `DEPTH_LOG2`, 6: buffer depth is `2**DEPTH_LOG2` entries (>=1).
- `TOKEN_RATIO`, 1: dequeued words per returned token (>=1).

- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `io_valid_in` in 1: IO beat valid.
- `io_data_in` in IO_W: IO beat data.
- `core_ready` in 1: core accepts head word this cycle.
- `core_valid_out` out 1: buffer non-empty.
- `core_data_out` out W: head word, first beat in bits [IO_W-1:0].
- `io_token_out` out 1: one-cycle credit pulse to transmitter.
- `count_out` out DEPTH_LOG2+1: number of words stored.
- `overflow_out` out 1: sticky; a completed word was dropped.

## Operation
- Beat counter `beat` (0..PACK-1) and staging register hold partial word. Each `io_valid_in` cycle stores `io_data_in` into slot `beat`; `beat` increments, wrapping PACK-1 -> 0.
- On the final beat (`beat==PACK-1`, or every beat when PACK=1) the assembled word {io_data_in, staged slots PACK-2..0} is written to `buf[wptr[DEPTH_LOG2-1:0]]` and `wptr` increments, unless full.
- Pointers `wptr`, `rptr` are DEPTH_LOG2+1 bits; MSB is the wrap bit. Empty: `wptr==rptr`. Full: address bits equal and wrap bits differ. `count_out = wptr - rptr` (modulo 2**(DEPTH_LOG2+1)).
- `core_valid_out = !empty`; `core_data_out = buf[rptr[DEPTH_LOG2-1:0]]` combinationally (FWFT). Dequeue when `core_valid_out & core_ready`: `rptr` increments. `core_ready` while empty has no effect.
- Full is evaluated on registered state: a final beat arriving while full is dropped even if a dequeue occurs in the same cycle. Dropped word: `overflow_out` set (cleared only by `rst`), `beat` still returns to 0, `wptr` unchanged.
- Simultaneous final-beat write and dequeue when neither full nor empty: both take effect; `count_out` unchanged.
- Write to and read from the same entry in one cycle is impossible (would require empty, where no read occurs); no bypass path.
- Token: counter `tcnt` (0..TOKEN_RATIO-1) increments on each dequeue; on a dequeue with `tcnt==TOKEN_RATIO-1`, `tcnt` -> 0 and `io_token_out` is asserted (registered) for the next cycle only.

## Timing
- Reset values: `beat=0`, `wptr=rptr=0`, `tcnt=0`, `core_valid_out=0`, `io_token_out=0`, `count_out=0`, `overflow_out=0`; `core_data_out` is the contents of entry 0 (buffer not reset, value don't-care while invalid).
- Latency: final beat sampled at edge N -> `core_valid_out=1` and data visible after edge N (same cycle as edge N+0 output settle, i.e. cycle N+1).
- Dequeue at edge M -> next word (or `core_valid_out=0`) visible in cycle M+1.
- Token: qualifying dequeue at edge M -> `io_token_out=1` during cycle M+1, 0 at M+2 unless another qualifying dequeue at M+1.
- `rst` asserted mid-word or mid-operation: partial beats discarded, buffer logically emptied, token count lost, asynchronously.
- Pointer wrap: after `2**DEPTH_LOG2` writes `wptr` address returns to 0 with wrap bit toggled; no other effect.

## Test plan
- Params 8/2/2/1: beats 0x11,0x22 -> one cycle later `core_valid_out=1`, `core_data_out=0x2211`, `count_out=1`; `core_ready=1` -> `io_token_out` pulses one cycle, `count_out=0`.
- Fill 4 words (8 beats, ready low) -> `count_out=4`, full; 2 more beats 0xAA,0xBB -> `overflow_out=1`, `count_out=4`, drained words unchanged, 0xBBAA never appears.
- Stream 20 words with `core_ready=1` continuously -> in-order output, pointers wrap twice, `count_out` never exceeds 1, 20 token pulses.
- `TOKEN_RATIO=3`: dequeue 7 words -> exactly 2 `io_token_out` pulses, after the 3rd and 6th dequeue.
- Assert `rst` after one beat of a 2-beat word, then send 0x01,0x02 -> output word 0x0201 (no stale byte), `overflow_out=0`.
- `PACK=4`, `IO_W=4`: beats 1,2,3,4 -> `core_data_out=0x4321`; final beat with simultaneous dequeue at count 2 -> `count_out` stays 2.
